// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Shares one Memory port between the ICache refill port (read-only) and the
//   data-side port (read/write). Round-robin grant, one transaction in flight,
//   optional response timeout that completes the transaction with bus_error.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   i_read_request      ICache read request (level, held until i_read_response)
//   i_addr              ICache address
//   i_read_response     one-cycle pulse: i_read_data valid
//   i_read_data         read data to ICache
//   d_read_request      data-side read request (level)
//   d_write_request     data-side write request (level, wins over read)
//   d_addr              data-side address
//   d_write_data        data-side write data
//   d_response          one-cycle pulse: read data valid or write done
//   d_read_data         read data to data side
//   bus_error           pulses with the response of a timed-out transaction
//   memory_read         Memory read strobe (held until memory_response)
//   memory_write        Memory write strobe (held until memory_response)
//   memory_addr         Memory address
//   memory_write_data   Memory write data
//   memory_read_data    Memory read data
//   memory_response     Memory completion
module memory_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_read_request,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_read_response,
    output logic [DATA_WIDTH-1:0] i_read_data,
    input  logic                  d_read_request,
    input  logic                  d_write_request,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_write_data,
    output logic                  d_response,
    output logic [DATA_WIDTH-1:0] d_read_data,
    output logic                  bus_error,
    output logic                  memory_read,
    output logic                  memory_write,
    output logic [ADDR_WIDTH-1:0] memory_addr,
    output logic [DATA_WIDTH-1:0] memory_write_data,
    input  logic [DATA_WIDTH-1:0] memory_read_data,
    input  logic                  memory_response
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    state_t                state, state_next;
    logic                  last_grant_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] i_data_q;
    logic [DATA_WIDTH-1:0] d_data_q;
    logic [CNT_W-1:0]      timeout_cnt;

    logic                  d_any;
    logic                  pick_i;
    logic                  pick_d;
    logic                  granted;
    logic                  timeout_hit;
    logic                  done;
    logic [DATA_WIDTH-1:0] resp_data;

    // Arbitration: on contention the port that did not win last time goes next.
    always_comb begin
        d_any       = d_read_request | d_write_request;
        pick_i      = (state == IDLE) & i_read_request & (~d_any | last_grant_d);
        pick_d      = (state == IDLE) & d_any & (~i_read_request | ~last_grant_d);
        granted     = (state != IDLE);
        // A real response in the last allowed cycle takes priority over the abort.
        timeout_hit = TIMEOUT_EN & granted & ~memory_response & (timeout_cnt == CNT_LAST);
        done        = granted & (memory_response | timeout_hit);
        resp_data   = timeout_hit ? '0 : memory_read_data;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (pick_i)      state_next = GRANT_I;
                else if (pick_d) state_next = GRANT_D;
            end
            GRANT_I, GRANT_D: begin
                if (done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        memory_read       = (state == GRANT_I) | ((state == GRANT_D) & ~write_q);
        memory_write      = (state == GRANT_D) & write_q;
        memory_addr       = addr_q;
        memory_write_data = wdata_q;
        i_read_response   = (state == GRANT_I) & done;
        d_response        = (state == GRANT_D) & done;
        bus_error         = timeout_hit;
        i_read_data       = i_read_response ? resp_data : i_data_q;
        d_read_data       = d_response ? resp_data : d_data_q;
    end

    // Transaction capture, grant history, timeout counter, held read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_d <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            i_data_q     <= '0;
            d_data_q     <= '0;
            timeout_cnt  <= '0;
        end else begin
            if (pick_i) begin
                last_grant_d <= 1'b0;
                addr_q       <= i_addr;
                wdata_q      <= '0;
                write_q      <= 1'b0;
                timeout_cnt  <= '0;
            end else if (pick_d) begin
                last_grant_d <= 1'b1;
                addr_q       <= d_addr;
                wdata_q      <= d_write_data;
                write_q      <= d_write_request;
                timeout_cnt  <= '0;
            end else if (granted & ~done) begin
                timeout_cnt  <= timeout_cnt + CNT_W'(1);
            end
            if (i_read_response) i_data_q <= resp_data;
            if (d_response)      d_data_q <= resp_data;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_read_request = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_read_response;
    logic [31:0] i_read_data;
    logic        d_read_request = 1'b0;
    logic        d_write_request = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_write_data = '0;
    logic        d_response;
    logic [31:0] d_read_data;
    logic        bus_error;
    logic        memory_read;
    logic        memory_write;
    logic [31:0] memory_addr;
    logic [31:0] memory_write_data;
    logic [31:0] memory_read_data = '0;
    logic        memory_response = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Memory model controls
    logic        mem_en = 1'b1;
    int          mem_lat = 2;
    int          mcnt = 0;
    logic        last_op_write = 1'b0;
    logic [31:0] mem [0:63];

    memory_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .i_read_request   (i_read_request),
        .i_addr           (i_addr),
        .i_read_response  (i_read_response),
        .i_read_data      (i_read_data),
        .d_read_request   (d_read_request),
        .d_write_request  (d_write_request),
        .d_addr           (d_addr),
        .d_write_data     (d_write_data),
        .d_response       (d_response),
        .d_read_data      (d_read_data),
        .bus_error        (bus_error),
        .memory_read      (memory_read),
        .memory_write     (memory_write),
        .memory_addr      (memory_addr),
        .memory_write_data(memory_write_data),
        .memory_read_data (memory_read_data),
        .memory_response  (memory_response)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Memory: responds in the mem_lat-th cycle a strobe is seen, for one cycle.
    always @(posedge clk) begin
        #1;
        if (memory_response) begin
            memory_response = 1'b0;
            mcnt = 0;
        end else if ((memory_read || memory_write) && mem_en) begin
            mcnt++;
            if (mcnt == mem_lat) begin
                if (memory_write) begin
                    mem[memory_addr[7:2]] = memory_write_data;
                    last_op_write = 1'b1;
                end else begin
                    memory_read_data = mem[memory_addr[7:2]];
                    last_op_write = 1'b0;
                end
                memory_response = 1'b1;
            end
        end else begin
            mcnt = 0;
        end
    end

    task automatic i_txn(input logic [31:0] a, output logic [31:0] data,
                         output logic berr, output int rcyc, output logic ok);
        ok = 1'b0; data = '0; berr = 1'b0; rcyc = 0;
        @(negedge clk);
        i_read_request = 1'b1;
        i_addr = a;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (i_read_response) begin
                data = i_read_data; berr = bus_error; rcyc = cyc; ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        i_read_request = 1'b0;
    endtask

    task automatic d_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] data, output logic berr,
                         output int rcyc, output logic ok);
        ok = 1'b0; data = '0; berr = 1'b0; rcyc = 0;
        @(negedge clk);
        d_write_request = wr;
        d_read_request = ~wr;
        d_addr = a;
        d_write_data = wd;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (d_response) begin
                data = d_read_data; berr = bus_error; rcyc = cyc; ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        d_write_request = 1'b0;
        d_read_request = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({memory_read, memory_write, i_read_response, d_response, bus_error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 00000",
                     {memory_read, memory_write, i_read_response, d_response, bus_error});
        end
        checks++;
        if (memory_addr !== 32'h0 || memory_write_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem_bus: addr=%h wdata=%h expected 0/0", memory_addr, memory_write_data);
        end
        checks++;
        if (i_read_data !== 32'h0 || d_read_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_read_data: i=%h d=%h expected 0/0", i_read_data, d_read_data);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (memory_read !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_request: memory_read=%b expected 0", memory_read);
        end
    endtask

    task automatic test_i_read;
        logic seen;
        @(negedge clk);
        i_read_request = 1'b1;
        i_addr = 32'h0;
        @(negedge clk);
        checks++;
        if (memory_read !== 1'b1 || memory_write !== 1'b0 || memory_addr !== 32'h0) begin
            errors++;
            $display("FAIL i_read_strobe: rd=%b wr=%b addr=%h expected 1/0/00000000",
                     memory_read, memory_write, memory_addr);
        end
        checks++;
        if (i_read_response !== 1'b0) begin
            errors++;
            $display("FAIL i_read_early_resp: got %b expected 0", i_read_response);
        end
        @(negedge clk);
        checks++;
        if (i_read_response !== 1'b1 || i_read_data !== 32'hC0DE0000 || bus_error !== 1'b0) begin
            errors++;
            $display("FAIL i_read_resp: resp=%b data=%h err=%b expected 1/c0de0000/0",
                     i_read_response, i_read_data, bus_error);
        end
        @(posedge clk); #1;
        i_read_request = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (memory_read || i_read_response) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL i_read_single: extra strobe/response seen=%b expected 0", seen);
        end
        checks++;
        if (i_read_data !== 32'hC0DE0000) begin
            errors++;
            $display("FAIL i_read_hold: got %h expected c0de0000", i_read_data);
        end
    endtask

    task automatic test_d_write_read;
        logic [31:0] data;
        logic berr, ok;
        int rc;
        d_txn(1'b1, 32'h10, 32'hDEADBEEF, data, berr, rc, ok);
        checks++;
        if (ok !== 1'b1 || berr !== 1'b0 || last_op_write !== 1'b1) begin
            errors++;
            $display("FAIL d_write: ok=%b err=%b write_op=%b expected 1/0/1", ok, berr, last_op_write);
        end
        checks++;
        if (mem[4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL d_write_mem: got %h expected deadbeef", mem[4]);
        end
        d_txn(1'b0, 32'h10, 32'h0, data, berr, rc, ok);
        checks++;
        if (ok !== 1'b1 || data !== 32'hDEADBEEF || berr !== 1'b0 || last_op_write !== 1'b0) begin
            errors++;
            $display("FAIL d_read: ok=%b data=%h err=%b write_op=%b expected 1/deadbeef/0/0",
                     ok, data, berr, last_op_write);
        end
        checks++;
        if (i_read_data !== 32'hC0DE0000 || d_read_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_data_hold: i=%h d=%h expected c0de0000/deadbeef", i_read_data, d_read_data);
        end
    endtask

    task automatic test_contend;
        logic [31:0] id, dd;
        logic ib, db, iok, dok;
        int ic, dc;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        fork
            i_txn(32'h4, id, ib, ic, iok);
            d_txn(1'b0, 32'h8, 32'h0, dd, db, dc, dok);
        join
        checks++;
        if (iok !== 1'b1 || id !== 32'hC0DE0001) begin
            errors++;
            $display("FAIL contend_i: ok=%b data=%h expected 1/c0de0001", iok, id);
        end
        checks++;
        if (dok !== 1'b1 || dd !== 32'hC0DE0002) begin
            errors++;
            $display("FAIL contend_d: ok=%b data=%h expected 1/c0de0002", dok, dd);
        end
        checks++;
        if (dc - ic !== 3) begin
            errors++;
            $display("FAIL contend_order: d-i response gap=%0d expected 3", dc - ic);
        end
    endtask

    task automatic test_back_to_back;
        int order[$];
        fork
            begin
                logic [31:0] data; logic berr, ok; int rc;
                for (int k = 0; k < 3; k++) begin
                    i_txn(32'h0, data, berr, rc, ok);
                    if (ok) order.push_back(0);
                end
            end
            begin
                logic [31:0] data; logic berr, ok; int rc;
                for (int k = 0; k < 3; k++) begin
                    d_txn(1'b0, 32'h8, 32'h0, data, berr, rc, ok);
                    if (ok) order.push_back(1);
                end
            end
        join
        checks++;
        if (order.size() !== 6) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 6", order.size());
        end
        for (int k = 0; k < order.size(); k++) begin
            checks++;
            if (order[k] !== (k % 2)) begin
                errors++;
                $display("FAIL b2b_grant%0d: got port %0d expected %0d (0=I,1=D)", k, order[k], k % 2);
            end
        end
    endtask

    task automatic test_timeout;
        int glen;
        logic got, berr;
        logic [31:0] data;
        mem_en = 1'b0;
        glen = 0; got = 1'b0; berr = 1'b0; data = 32'hFFFFFFFF;
        @(negedge clk);
        i_read_request = 1'b1;
        i_addr = 32'h4;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (memory_read) glen++;
            if (i_read_response) begin
                got = 1'b1; berr = bus_error; data = i_read_data;
                break;
            end
        end
        @(posedge clk); #1;
        i_read_request = 1'b0;
        checks++;
        if (got !== 1'b1 || glen !== 8) begin
            errors++;
            $display("FAIL timeout_cycle: resp=%b grant_cycles=%0d expected 1/8", got, glen);
        end
        checks++;
        if (berr !== 1'b1 || data !== 32'h0) begin
            errors++;
            $display("FAIL timeout_err: bus_error=%b data=%h expected 1/00000000", berr, data);
        end
        @(negedge clk);
        checks++;
        if (memory_read !== 1'b0 || bus_error !== 1'b0 || i_read_response !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: rd=%b err=%b resp=%b expected 0/0/0",
                     memory_read, bus_error, i_read_response);
        end
        mem_en = 1'b1;
    endtask

    task automatic test_reset_mid;
        logic seen;
        logic [31:0] data;
        logic berr, ok;
        int rc;
        mem_en = 1'b0;
        @(negedge clk);
        d_read_request = 1'b1;
        d_addr = 32'h8;
        @(negedge clk);
        checks++;
        if (memory_read !== 1'b1) begin
            errors++;
            $display("FAIL rmid_granted: memory_read=%b expected 1", memory_read);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (memory_read !== 1'b0 || memory_write !== 1'b0 || d_response !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async: rd=%b wr=%b d_resp=%b expected 0/0/0",
                     memory_read, memory_write, d_response);
        end
        seen = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (d_response || memory_read || bus_error) seen = 1'b1;
        end
        d_read_request = 1'b0;
        @(negedge clk);
        if (d_response) seen = 1'b1;
        reset = 1'b1;
        mem_en = 1'b1;
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rmid_quiet: activity during reset=%b expected 0", seen);
        end
        i_txn(32'h4, data, berr, rc, ok);
        checks++;
        if (ok !== 1'b1 || data !== 32'hC0DE0001 || berr !== 1'b0) begin
            errors++;
            $display("FAIL rmid_recover: ok=%b data=%h err=%b expected 1/c0de0001/0", ok, data, berr);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE0000 | i;
        test_reset;
        test_i_read;
        test_d_write_read;
        test_contend;
        test_back_to_back;
        test_timeout;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
